tlb_assoc_param: RTL and testbench

Parametrised fully associative TLB, successor to the fixed 8-entry TLB. Adds configurable depth and widths, ASID tagging with a global bit, and a MIPS-style wired region excluded from random replacement. Also adds a registered probe operation and a multi-cycle flush sequencer (all entries, or one ASID). Sits between the CP0 entry/index registers and the address-translation path of the pipeline.

---
 rtl/tlb_pkg.sv | 24 ++
 rtl/tlb_cam_param.sv | 76 +++++++
 rtl/tlb_assoc_param.sv | 140 ++++++++++++++
 tb/tb_tlb_assoc_param.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types for the parametrised associative TLB.
// Holds the default geometry, the entry record and the flush state encoding.
package tlb_pkg;

    localparam int TLB_ENTRIES = 16;
    localparam int TLB_VPN_W   = 20;
    localparam int TLB_PTE_W   = 24;
    localparam int TLB_ASID_W  = 8;
    localparam int TLB_WIRED   = 2;

    typedef struct packed {
        logic                  valid;
        logic [TLB_VPN_W-1:0]  vpn;
        logic [TLB_ASID_W-1:0] asid;
        logic                  g;
        logic [TLB_PTE_W-1:0]  pte;
    } tlb_entry_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } flush_state_e;

endpackage

// File: rtl/tlb_cam_param.sv
// Tag CAM of the TLB: valid/vpn/asid/g per entry, match vector and a
// lowest-index priority encoder shared by lookup and probe.
// Ports: clk, clrn; wr_* write port; clr_* single-entry flush port;
//        vpn/asid lookup key; hit, hit_idx result.
module tlb_cam_param
    import tlb_pkg::*;
#(
    parameter int ENTRIES = TLB_ENTRIES,
    parameter int VPN_W   = TLB_VPN_W,
    parameter int ASID_W  = TLB_ASID_W,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [VPN_W-1:0]  wr_vpn,
    input  logic [ASID_W-1:0] wr_asid,
    input  logic              wr_g,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx,
    input  logic              clr_asid_only,
    input  logic [ASID_W-1:0] clr_asid,
    input  logic [VPN_W-1:0]  vpn,
    input  logic [ASID_W-1:0] asid,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx
);

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] g;
    logic [ENTRIES-1:0] match;
    logic [VPN_W-1:0]   tag      [ENTRIES];
    logic [ASID_W-1:0]  asid_tag [ENTRIES];
    logic               clr_hit;

    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = valid[i] & (tag[i] == vpn)
                     & (g[i] | (asid_tag[i] == asid));
        end
    end

    // Scan downwards so the lowest matching index is the last one kept.
    always_comb begin
        hit     = |match;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = IDX_W'(i);
        end
    end

    assign clr_hit = clr_en &
                     (!clr_asid_only |
                      (!g[clr_idx] & (asid_tag[clr_idx] == clr_asid)));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid <= '0;
        end else begin
            if (wr_en)   valid[wr_idx]  <= 1'b1;
            if (clr_hit) valid[clr_idx] <= 1'b0;
        end
    end

    // Tags only matter while valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag[wr_idx]      <= wr_vpn;
            asid_tag[wr_idx] <= wr_asid;
            g[wr_idx]        <= wr_g;
        end
    end

endmodule

// File: rtl/tlb_assoc_param.sv
// Parametrised fully associative TLB with ASID/global tagging, wired
// region, registered probe and a one-entry-per-cycle flush sequencer.
// Ports: clk, clrn; vpn/asid key; pte_in/g_in write data; tlbwi, tlbwr,
//        tlbp, flush(+flush_asid_only), index; pte_out, tlb_hit,
//        probe_idx, probe_miss, random, busy.
module tlb_assoc_param
    import tlb_pkg::*;
#(
    parameter int ENTRIES = TLB_ENTRIES,
    parameter int VPN_W   = TLB_VPN_W,
    parameter int PTE_W   = TLB_PTE_W,
    parameter int ASID_W  = TLB_ASID_W,
    parameter int WIRED   = TLB_WIRED,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [VPN_W-1:0]  vpn,
    input  logic [ASID_W-1:0] asid,
    input  logic [PTE_W-1:0]  pte_in,
    input  logic              g_in,
    input  logic              tlbwi,
    input  logic              tlbwr,
    input  logic              tlbp,
    input  logic              flush,
    input  logic              flush_asid_only,
    input  logic [IDX_W-1:0]  index,
    output logic [PTE_W-1:0]  pte_out,
    output logic              tlb_hit,
    output logic [IDX_W-1:0]  probe_idx,
    output logic              probe_miss,
    output logic [IDX_W-1:0]  random,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W-1:0] FLOOR = IDX_W'(WIRED);

    flush_state_e      state;
    flush_state_e      state_nxt;
    logic [IDX_W-1:0]  cnt;
    logic              fl_asid_only;
    logic [ASID_W-1:0] fl_asid;

    logic              accept;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              cam_hit;
    logic [IDX_W-1:0]  cam_idx;
    logic [PTE_W-1:0]  pte_mem [ENTRIES];

    assign busy   = (state == FLUSH);
    // A flush request pre-empts any other operation in the same cycle.
    assign accept = !busy & !flush;
    assign wr_en  = accept & (tlbwi | tlbwr);
    assign wr_idx = tlbwi ? index : random;

    tlb_cam_param #(
        .ENTRIES (ENTRIES),
        .VPN_W   (VPN_W),
        .ASID_W  (ASID_W),
        .IDX_W   (IDX_W)
    ) u_cam (
        .clk           (clk),
        .clrn          (clrn),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_vpn        (vpn),
        .wr_asid       (asid),
        .wr_g          (g_in),
        .clr_en        (busy),
        .clr_idx       (cnt),
        .clr_asid_only (fl_asid_only),
        .clr_asid      (fl_asid),
        .vpn           (vpn),
        .asid          (asid),
        .hit           (cam_hit),
        .hit_idx       (cam_idx)
    );

    assign tlb_hit = cam_hit & !busy & !(tlbwi | tlbwr);
    assign pte_out = tlb_hit ? pte_mem[cam_idx] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) pte_mem[wr_idx] <= pte_in;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            random <= LAST;
        end else if (random == FLOOR) begin
            random <= LAST;
        end else begin
            random <= random - 1'b1;
        end
    end

    // Probe misses leave the previous index in place.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            probe_idx  <= '0;
            probe_miss <= 1'b1;
        end else if (accept && tlbp) begin
            probe_miss <= !cam_hit;
            if (cam_hit) probe_idx <= cam_idx;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (flush) state_nxt = FLUSH;
            FLUSH: if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt          <= '0;
            fl_asid_only <= 1'b0;
            fl_asid      <= '0;
        end else if (!busy && flush) begin
            cnt          <= '0;
            fl_asid_only <= flush_asid_only;
            fl_asid      <= asid;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tlb_assoc_param.sv
// Scoreboard bench for tlb_assoc_param: stimulus pushes per-cycle
// expectations from a reference model, a negedge monitor compares them.
module tb_tlb_assoc_param;
    import tlb_pkg::*;

    localparam int N   = 16;
    localparam int VW  = 20;
    localparam int PW  = 24;
    localparam int AW  = 8;
    localparam int WIR = 2;
    localparam int IW  = 4;

    logic          clk;
    logic          clrn;
    logic [VW-1:0] vpn;
    logic [AW-1:0] asid;
    logic [PW-1:0] pte_in;
    logic          g_in;
    logic          tlbwi;
    logic          tlbwr;
    logic          tlbp;
    logic          flush;
    logic          flush_asid_only;
    logic [IW-1:0] index;
    logic [PW-1:0] pte_out;
    logic          tlb_hit;
    logic [IW-1:0] probe_idx;
    logic          probe_miss;
    logic [IW-1:0] random;
    logic          busy;

    tlb_assoc_param #(
        .ENTRIES (N),
        .VPN_W   (VW),
        .PTE_W   (PW),
        .ASID_W  (AW),
        .WIRED   (WIR)
    ) dut (
        .clk             (clk),
        .clrn            (clrn),
        .vpn             (vpn),
        .asid            (asid),
        .pte_in          (pte_in),
        .g_in            (g_in),
        .tlbwi           (tlbwi),
        .tlbwr           (tlbwr),
        .tlbp            (tlbp),
        .flush           (flush),
        .flush_asid_only (flush_asid_only),
        .index           (index),
        .pte_out         (pte_out),
        .tlb_hit         (tlb_hit),
        .probe_idx       (probe_idx),
        .probe_miss      (probe_miss),
        .random          (random),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic [PW-1:0] pte;
        logic [IW-1:0] pidx;
        logic          pmiss;
        logic [IW-1:0] rnd;
        logic          busy;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: plain table of entries plus flush bookkeeping.
    tlb_entry_t    m_ent [N];
    bit            m_fl;
    int            m_pos;
    bit            m_fao;
    logic [AW-1:0] m_fasid;
    logic [IW-1:0] m_pidx;
    bit            m_pmiss;
    int            m_edges;

    function automatic int m_find(logic [VW-1:0] v, logic [AW-1:0] a);
        for (int i = 0; i < N; i++) begin
            if (m_ent[i].valid && m_ent[i].vpn == v &&
                (m_ent[i].g || m_ent[i].asid == a))
                return i;
        end
        return -1;
    endfunction

    function automatic logic [IW-1:0] m_rand();
        return IW'(N - 1 - (m_edges % (N - WIR)));
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_ent[i].valid = 1'b0;
        m_fl    = 0;
        m_pos   = 0;
        m_pidx  = '0;
        m_pmiss = 1;
        m_edges = 0;
    endfunction

    function automatic void push_exp();
        exp_t e;
        int   f;
        f      = m_find(vpn, asid);
        e.hit  = (f >= 0) && !m_fl && !(tlbwi || tlbwr);
        e.pte  = e.hit ? m_ent[f].pte : '0;
        e.pidx = m_pidx;
        e.pmiss = m_pmiss;
        e.rnd  = m_rand();
        e.busy = m_fl;
        sbq.push_back(e);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("tlb_hit", 32'(tlb_hit), 32'(e.hit));
            chk("pte_out", 32'(pte_out), 32'(e.pte));
            chk("probe_idx", 32'(probe_idx), 32'(e.pidx));
            chk("probe_miss", 32'(probe_miss), 32'(e.pmiss));
            chk("random", 32'(random), 32'(e.rnd));
            chk("busy", 32'(busy), 32'(e.busy));
        end
    end

    // One clock cycle: expectation for the current inputs, then the edge.
    task automatic tick();
        bit            s_wi, s_wr, s_p, s_fl, s_fao, s_g;
        logic [IW-1:0] s_idx, r, w;
        logic [VW-1:0] s_vpn;
        logic [AW-1:0] s_asid;
        logic [PW-1:0] s_pte;
        int            f;
        push_exp();
        s_wi = tlbwi; s_wr = tlbwr; s_p = tlbp; s_fl = flush;
        s_fao = flush_asid_only; s_g = g_in; s_idx = index;
        s_vpn = vpn; s_asid = asid; s_pte = pte_in;
        f = m_find(vpn, asid);
        r = m_rand();
        @(posedge clk);
        #1;
        if (m_fl) begin
            if (!m_fao || (!m_ent[m_pos].g && m_ent[m_pos].asid == m_fasid))
                m_ent[m_pos].valid = 1'b0;
            m_pos++;
            if (m_pos == N) m_fl = 0;
        end else if (s_fl) begin
            m_fl    = 1;
            m_pos   = 0;
            m_fao   = s_fao;
            m_fasid = s_asid;
        end else begin
            if (s_p) begin
                m_pmiss = (f < 0);
                if (f >= 0) m_pidx = IW'(f);
            end
            if (s_wi || s_wr) begin
                w = s_wi ? s_idx : r;
                m_ent[w].valid = 1'b1;
                m_ent[w].vpn   = s_vpn;
                m_ent[w].asid  = s_asid;
                m_ent[w].g     = s_g;
                m_ent[w].pte   = s_pte;
            end
        end
        m_edges++;
        tlbwi = 0; tlbwr = 0; tlbp = 0; flush = 0;
    endtask

    task automatic rst_cycles(int n);
        clrn = 1'b0;
        m_reset();
        for (int i = 0; i < n; i++) begin
            push_exp();
            @(posedge clk);
            #1;
        end
        clrn = 1'b1;
    endtask

    task automatic wr_idx(logic [IW-1:0] i, logic [VW-1:0] v,
                          logic [AW-1:0] a, logic g, logic [PW-1:0] p);
        index = i; vpn = v; asid = a; g_in = g; pte_in = p; tlbwi = 1;
        tick();
    endtask

    task automatic look(logic [VW-1:0] v, logic [AW-1:0] a);
        vpn = v; asid = a;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 0; vpn = '0; asid = '0; pte_in = '0; g_in = 0;
        tlbwi = 0; tlbwr = 0; tlbp = 0; flush = 0;
        flush_asid_only = 0; index = '0;
        m_reset();
        @(posedge clk);
        #1;
        rst_cycles(3);
        for (int i = 0; i < 30; i++) tick();

        wr_idx(4'd3, 20'h12345, 8'd5, 1'b0, 24'hABCDEF);
        look(20'h12345, 8'd5);
        look(20'h12345, 8'd6);

        wr_idx(4'd7, 20'h00042, 8'd9, 1'b1, 24'h000777);
        look(20'h00042, 8'd1);
        look(20'h00042, 8'd200);

        wr_idx(4'd4, 20'h00777, 8'd5, 1'b0, 24'h444444);
        wr_idx(4'd9, 20'h00777, 8'd5, 1'b0, 24'h999999);
        look(20'h00777, 8'd5);
        tlbp = 1;
        look(20'h00777, 8'd5);
        tick();
        tlbp = 1;
        look(20'h0BEEF, 8'd5);
        tick();

        wr_idx(4'd0, 20'h000A0, 8'd5, 1'b0, 24'h0000A0);
        wr_idx(4'd1, 20'h000A1, 8'd5, 1'b0, 24'h0000A1);
        for (int i = 0; i < 100; i++) begin
            vpn = 20'($urandom) | 20'h80000;
            asid = 8'd5; g_in = 0; pte_in = 24'($urandom);
            tlbwr = 1;
            tick();
            tlbp = 1;
            tick();
        end
        look(20'h000A0, 8'd5);
        look(20'h000A1, 8'd5);

        wr_idx(4'd10, 20'h00500, 8'd5, 1'b0, 24'h500500);
        wr_idx(4'd11, 20'h00501, 8'd5, 1'b1, 24'h501501);
        wr_idx(4'd12, 20'h00502, 8'd6, 1'b0, 24'h502502);
        asid = 8'd5; flush_asid_only = 1; flush = 1; tlbwi = 1;
        tick();
        flush_asid_only = 0;
        for (int i = 0; i < 5; i++) tick();
        wr_idx(4'd13, 20'h00503, 8'd5, 1'b0, 24'h503503);
        for (int i = 0; i < 12; i++) tick();
        look(20'h00500, 8'd5);
        look(20'h00501, 8'd5);
        look(20'h00501, 8'd6);
        look(20'h00502, 8'd6);
        look(20'h00503, 8'd5);
        look(20'h00042, 8'd5);

        flush_asid_only = 0; flush = 1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst_cycles(2);
        look(20'h00502, 8'd6);
        look(20'h00042, 8'd5);
        look(20'h00501, 8'd5);

        for (int i = 0; i < 400; i++) begin
            int op;
            vpn    = 20'h00100 + 20'($urandom_range(0, 7));
            asid   = 8'($urandom_range(5, 6));
            g_in   = ($urandom_range(0, 3) == 0);
            pte_in = 24'($urandom);
            index  = 4'($urandom);
            op     = $urandom_range(0, 99);
            tlbwi  = (op < 15);
            tlbwr  = (op >= 10 && op < 30);
            tlbp   = (op >= 25 && op < 50);
            flush  = (op >= 97);
            flush_asid_only = $urandom_range(0, 1);
            tick();
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
